// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, the PC increment constant and return-stack op encoding
package cpu_pkg;
  localparam int ADDR_W = 8;
  localparam int RSTACK_DEPTH = 8;
  localparam int RSTACK_PTR_W = $clog2(RSTACK_DEPTH);
  localparam logic [ADDR_W-1:0] PC_INC = 8'b00000001;
  typedef enum logic [1:0] {OP_NONE = 2'b00, OP_POP = 2'b01, OP_PUSH = 2'b10, OP_SWAP = 2'b11} rs_op_e;
endpackage

// File: rtl/rstack_mem.sv
// rstack_mem: DEPTH x WIDTH register file, synchronous write, combinational read
module rstack_mem
  import cpu_pkg::*;
#(
  parameter int WIDTH = ADDR_W,
  parameter int DEPTH = RSTACK_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/ret_stack.sv
// ret_stack: return-address stack; push stores pc_in+1, pop returns the top to the PC load path
module ret_stack
  import cpu_pkg::*;
#(
  parameter int WIDTH = ADDR_W,
  parameter int DEPTH = RSTACK_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] ret_addr,
  output logic             ret_valid,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);
  localparam logic [PTR_W:0] ONE = (PTR_W+1)'(1);
  rs_op_e           op;
  logic             do_push, do_pop, ovf_set, unf_set;
  logic [PTR_W-1:0] waddr, raddr;
  logic [WIDTH-1:0] rdata;
  logic [PTR_W:0]   count_nxt;
  assign full  = count == (PTR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign raddr = count[PTR_W-1:0] - PTR_W'(1);
  always_comb begin
    op        = rs_op_e'({push, pop});
    do_pop    = pop && !empty;
    // a swap never grows the stack, so it is allowed even when full
    do_push   = push && (pop || !full);
    waddr     = (op == OP_SWAP && !empty) ? raddr : count[PTR_W-1:0];
    count_nxt = (do_push && !do_pop) ? count + ONE : (do_pop && !do_push) ? count - ONE : count;
    ovf_set   = op == OP_PUSH && full;
    unf_set   = pop && empty;
  end
  rstack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (waddr),
    .wdata (pc_in + WIDTH'(PC_INC)),
    .raddr (raddr),
    .rdata (rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count     <= '0;
      ret_addr  <= '0;
      ret_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      ret_addr  <= do_pop ? rdata : ret_addr;
      ret_valid <= do_pop;
      overflow  <= ovf_set | (overflow & ~err_clr);
      underflow <= unf_set | (underflow & ~err_clr);
    end
endmodule
